// File: rtl/pipeline_mem_arbiter.sv
// -----------------------------------------------------------------------------
// pipeline_mem_arbiter
//
// Purpose: shares one downstream memory port between the instruction-fetch
// and data ports of a pipeline. Data normally wins. However, an instruction
// fetch cannot be starved by more than STARVE_LIMIT consecutive data grants.
// The winning request is captured on the grant edge, and only the captured
// copy drives mem_*. The downstream transaction therefore stays stable until
// mem_resp, whatever the pipeline does upstream.
//
// Ports:
//   clk, reset             clock (rising edge) / asynchronous active-low reset
//   inst_read, inst_addr   instruction fetch request and address
//   inst_resp, inst_rdata  fetch done pulse and fetched word (0 when no resp)
//   data_read, data_write  data load / store requests (write wins if both)
//   data_addr, data_wdata, data_mbe  data address, store data, byte enables
//   data_resp, data_rdata  data done pulse and load word (0 when no resp)
//   mem_read, mem_write    downstream request strobes
//   mem_addr, mem_wdata, mem_mbe     downstream address, write data, enables
//   mem_resp, mem_rdata    downstream completion and read data
// -----------------------------------------------------------------------------
module pipeline_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_read,
    input  logic [31:0] inst_addr,
    output logic        inst_resp,
    output logic [31:0] inst_rdata,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_mbe,
    output logic        data_resp,
    output logic [31:0] data_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_mbe,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       mbe_q, mbe_d;
    logic             write_q, write_d;

    logic data_req;
    logic data_win;
    logic grant_data;
    logic grant_inst;

    // A pending fetch only blocks data once the starvation budget is spent.
    assign data_req   = data_read | data_write;
    assign data_win   = data_req & (~inst_read | (starve_cnt_q < LIMIT_C));
    assign grant_data = (state_q == IDLE) & data_win;
    assign grant_inst = (state_q == IDLE) & ~data_win & inst_read;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (data_win) begin
                    state_d = DATA;
                end else if (inst_read) begin
                    state_d = INST;
                end
            end
            INST, DATA: begin
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture of the winning request and starvation accounting
    always_comb begin
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mbe_d        = mbe_q;
        write_d      = write_q;
        starve_cnt_d = starve_cnt_q;
        if (grant_data) begin
            addr_d  = data_addr;
            wdata_d = data_wdata;
            mbe_d   = data_mbe;
            // A simultaneous read and write is treated as a write.
            write_d = data_write;
            if (inst_read && (starve_cnt_q != LIMIT_C)) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end else if (grant_inst) begin
            // Fetches are full-word reads with no write data.
            addr_d       = inst_addr;
            wdata_d      = '0;
            mbe_d        = 4'b1111;
            write_d      = 1'b0;
            starve_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            mbe_q        <= '0;
            write_q      <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mbe_q        <= mbe_d;
            write_q      <= write_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Output logic: everything is 0 in IDLE. This also covers reset, because
    // reset forces IDLE. A mem_resp arriving in IDLE is ignored.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_mbe    = '0;
        inst_resp  = 1'b0;
        inst_rdata = '0;
        data_resp  = 1'b0;
        data_rdata = '0;
        case (state_q)
            INST: begin
                mem_read  = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_mbe   = mbe_q;
                inst_resp = mem_resp;
                if (mem_resp) begin
                    inst_rdata = mem_rdata;
                end
            end
            DATA: begin
                mem_read  = ~write_q;
                mem_write = write_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_mbe   = mbe_q;
                data_resp = mem_resp;
                if (mem_resp) begin
                    data_rdata = mem_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
`timescale 1ns/1ps
module tb_pipeline_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_read;
    logic [31:0] inst_addr;
    logic        inst_resp;
    logic [31:0] inst_rdata;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_mbe;
    logic        data_resp;
    logic [31:0] data_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mbe;
    logic        mem_resp;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    pipeline_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .inst_read  (inst_read),
        .inst_addr  (inst_addr),
        .inst_resp  (inst_resp),
        .inst_rdata (inst_rdata),
        .data_read  (data_read),
        .data_write (data_write),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_mbe   (data_mbe),
        .data_resp  (data_resp),
        .data_rdata (data_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_mbe    (mem_mbe),
        .mem_resp   (mem_resp),
        .mem_rdata  (mem_rdata)
    );

    typedef struct packed {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [3:0]  dm;
        logic        mresp;
        logic [31:0] mrd;
    } ins_t;

    typedef struct packed {
        logic        inst_resp;
        logic [31:0] inst_rdata;
        logic        data_resp;
        logic [31:0] data_rdata;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_mbe;
    } outs_t;

    typedef struct {
        ins_t  in;
        outs_t exp;
    } vec_t;

    typedef struct {
        bit          is_inst;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mbe;
    } txn_t;

    int    n_cmp  = 0;
    int    n_fail = 0;
    outs_t Z      = '0;
    vec_t  tbl[18];

    // Reference model: at most one transaction owns the port.
    txn_t inflight[$];
    int   m_starve;

    function automatic ins_t mk_in(logic ir, logic [31:0] ia, logic dr, logic dw,
                                   logic [31:0] da, logic [31:0] dwd, logic [3:0] dm,
                                   logic mr, logic [31:0] mrd);
        ins_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da;
        v.dwd = dwd; v.dm = dm; v.mresp = mr; v.mrd = mrd;
        return v;
    endfunction

    function automatic outs_t mk_out(logic irs, logic [31:0] ird, logic drs, logic [31:0] drd,
                                     logic mr, logic mw, logic [31:0] ma, logic [31:0] mwd,
                                     logic [3:0] mm);
        outs_t o;
        o.inst_resp = irs; o.inst_rdata = ird; o.data_resp = drs; o.data_rdata = drd;
        o.mem_read = mr; o.mem_write = mw; o.mem_addr = ma; o.mem_wdata = mwd; o.mem_mbe = mm;
        return o;
    endfunction

    function automatic outs_t actual();
        outs_t o;
        o.inst_resp = inst_resp; o.inst_rdata = inst_rdata;
        o.data_resp = data_resp; o.data_rdata = data_rdata;
        o.mem_read = mem_read; o.mem_write = mem_write; o.mem_addr = mem_addr;
        o.mem_wdata = mem_wdata; o.mem_mbe = mem_mbe;
        return o;
    endfunction

    task automatic apply(ins_t v);
        inst_read  = v.ir;
        inst_addr  = v.ia;
        data_read  = v.dr;
        data_write = v.dw;
        data_addr  = v.da;
        data_wdata = v.dwd;
        data_mbe   = v.dm;
        mem_resp   = v.mresp;
        mem_rdata  = v.mrd;
    endtask

    // Inputs change on the falling edge; outputs are sampled 2 ns later.
    task automatic cycle_apply(ins_t v);
        @(negedge clk);
        apply(v);
        #2;
    endtask

    task automatic chk(string name, outs_t act, outs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic set_vec(int i, ins_t a, outs_t b);
        tbl[i].in  = a;
        tbl[i].exp = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        // Drive every request active to show reset forces all outputs low.
        apply(mk_in(1, 32'h11, 1, 1, 32'h22, 32'h33, 4'hF, 1, 32'h44));
        reset = 1'b0;
        #1;
        chk("reset_outputs", actual(), Z);
        @(negedge clk);
        apply('0);
        reset = 1'b1;
    endtask

    function automatic outs_t model_out(ins_t v);
        outs_t e = '0;
        txn_t  t;
        if (inflight.size() != 0) begin
            t = inflight[0];
            e.mem_read  = !t.wr;
            e.mem_write = t.wr;
            e.mem_addr  = t.addr;
            e.mem_wdata = t.wdata;
            e.mem_mbe   = t.mbe;
            if (v.mresp) begin
                if (t.is_inst) begin
                    e.inst_resp = 1'b1; e.inst_rdata = v.mrd;
                end else begin
                    e.data_resp = 1'b1; e.data_rdata = v.mrd;
                end
            end
        end
        return e;
    endfunction

    task automatic model_step(ins_t v);
        txn_t t;
        if (inflight.size() != 0) begin
            if (v.mresp) void'(inflight.pop_front());
        end else if ((v.dr || v.dw) && (!v.ir || m_starve < LIMIT)) begin
            t.is_inst = 0; t.wr = v.dw; t.addr = v.da; t.wdata = v.dwd; t.mbe = v.dm;
            inflight.push_back(t);
            if (v.ir) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
        end else if (v.ir) begin
            t.is_inst = 1; t.wr = 0; t.addr = v.ia; t.wdata = 0; t.mbe = 4'hF;
            inflight.push_back(t);
            m_starve = 0;
        end
    endtask

    initial begin
        ins_t  v;
        outs_t e;
        bit    want_inst;

        reset = 1'b0;
        apply('0);

        // Single fetch, ignored IDLE resp, simultaneous requests, data read.
        set_vec(0,  mk_in(1, 32'h60, 0, 0, 0, 0, 0, 0, 0), Z);
        set_vec(1,  mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 1, 0, 32'h60, 0, 4'hF));
        set_vec(2,  mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 1, 0, 32'h60, 0, 4'hF));
        set_vec(3,  mk_in(0, 0, 0, 0, 0, 0, 0, 1, 32'h13), mk_out(1, 32'h13, 0, 0, 1, 0, 32'h60, 0, 4'hF));
        set_vec(4,  mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0), Z);
        set_vec(5,  mk_in(0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA5555), Z);
        set_vec(6,  mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0), Z);
        set_vec(7,  mk_in(1, 32'h400, 0, 1, 32'h100, 32'hDEADBEEF, 4'b0011, 0, 0), Z);
        set_vec(8,  mk_in(1, 32'h400, 0, 0, 32'h999, 0, 0, 0, 0),
                    mk_out(0, 0, 0, 0, 0, 1, 32'h100, 32'hDEADBEEF, 4'b0011));
        set_vec(9,  mk_in(1, 32'h400, 0, 0, 0, 0, 0, 1, 32'h55),
                    mk_out(0, 0, 1, 32'h55, 0, 1, 32'h100, 32'hDEADBEEF, 4'b0011));
        set_vec(10, mk_in(1, 32'h400, 0, 0, 0, 0, 0, 0, 0), Z);
        set_vec(11, mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 1, 0, 32'h400, 0, 4'hF));
        set_vec(12, mk_in(0, 0, 0, 0, 0, 0, 0, 1, 32'h77), mk_out(1, 32'h77, 0, 0, 1, 0, 32'h400, 0, 4'hF));
        set_vec(13, mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0), Z);
        set_vec(14, mk_in(0, 0, 1, 0, 32'h20, 32'h1234, 4'b0101, 0, 0), Z);
        set_vec(15, mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 1, 0, 32'h20, 32'h1234, 4'b0101));
        set_vec(16, mk_in(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D),
                    mk_out(0, 0, 1, 32'hCAFEF00D, 1, 0, 32'h20, 32'h1234, 4'b0101));
        set_vec(17, mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0), Z);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            cycle_apply(tbl[i].in);
            chk($sformatf("table[%0d]", i), actual(), tbl[i].exp);
        end

        // Starvation bound: both requests held, resp one cycle after each grant.
        do_reset();
        for (int g = 0; g < 2 * (LIMIT + 1); g++) begin
            cycle_apply(mk_in(1, 32'h1000, 1, 0, 32'h2000, 0, 0, 0, 0));
            chk($sformatf("starve_idle[%0d]", g), actual(), Z);
            cycle_apply(mk_in(1, 32'h1000, 1, 0, 32'h2000, 0, 0, 1, g));
            want_inst = ((g % (LIMIT + 1)) == LIMIT);
            e = want_inst ? mk_out(1, g, 0, 0, 1, 0, 32'h1000, 0, 4'hF)
                          : mk_out(0, 0, 1, g, 1, 0, 32'h2000, 0, 4'h0);
            chk($sformatf("starve_grant[%0d]", g), actual(), e);
        end
        cycle_apply('0);

        // Upstream address changes while DATA is in flight.
        cycle_apply(mk_in(0, 0, 1, 0, 32'h200, 0, 4'hF, 0, 0));
        chk("addr_hold_grant", actual(), Z);
        for (int k = 0; k < 2; k++) begin
            cycle_apply(mk_in(0, 0, 0, 0, 32'h300, 0, 4'h1, 0, 0));
            chk($sformatf("addr_hold[%0d]", k), actual(), mk_out(0, 0, 0, 0, 1, 0, 32'h200, 0, 4'hF));
        end
        cycle_apply(mk_in(0, 0, 0, 0, 32'h300, 0, 4'h1, 1, 32'h39));
        chk("addr_hold_resp", actual(), mk_out(0, 0, 1, 32'h39, 1, 0, 32'h200, 0, 4'hF));
        cycle_apply('0);
        chk("addr_hold_idle", actual(), Z);

        // Read and write together at grant: treated as a write.
        cycle_apply(mk_in(0, 0, 1, 1, 32'h44, 32'h11112222, 4'hF, 0, 0));
        cycle_apply('0);
        chk("rw_both", actual(), mk_out(0, 0, 0, 0, 0, 1, 32'h44, 32'h11112222, 4'hF));
        cycle_apply(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 32'h5A));
        chk("rw_both_resp", actual(), mk_out(0, 0, 1, 32'h5A, 0, 1, 32'h44, 32'h11112222, 4'hF));
        cycle_apply('0);

        // Reset in the middle of a fetch, then a stray mem_resp.
        cycle_apply(mk_in(1, 32'h80, 0, 0, 0, 0, 0, 0, 0));
        cycle_apply('0);
        chk("pre_reset_inst", actual(), mk_out(0, 0, 0, 0, 1, 0, 32'h80, 0, 4'hF));
        #1;
        reset     = 1'b0;
        mem_resp  = 1'b1;
        mem_rdata = 32'h1234;
        #1;
        chk("reset_mid_txn", actual(), Z);
        @(negedge clk);
        reset = 1'b1;
        apply(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 32'h99));
        #2;
        chk("resp_after_reset", actual(), Z);
        cycle_apply(mk_in(1, 32'hC0, 0, 0, 0, 0, 0, 0, 0));
        chk("post_reset_idle", actual(), Z);
        cycle_apply('0);
        chk("post_reset_grant", actual(), mk_out(0, 0, 0, 0, 1, 0, 32'hC0, 0, 4'hF));
        cycle_apply(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 32'h7));
        chk("post_reset_resp", actual(), mk_out(1, 32'h7, 0, 0, 1, 0, 32'hC0, 0, 4'hF));
        cycle_apply('0);

        // Random traffic against the transaction-level model.
        do_reset();
        inflight.delete();
        m_starve = 0;
        for (int c = 0; c < 3000; c++) begin
            v.ir    = ($urandom_range(0, 1) == 0);
            v.ia    = $urandom;
            v.dr    = ($urandom_range(0, 2) == 0);
            v.dw    = ($urandom_range(0, 3) == 0);
            v.da    = $urandom;
            v.dwd   = $urandom;
            v.dm    = 4'($urandom_range(0, 15));
            v.mresp = ($urandom_range(0, 2) == 0);
            v.mrd   = $urandom;
            cycle_apply(v);
            chk("random", actual(), model_out(v));
            model_step(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_mem_arbiter.md
PIPELINE_MEM_ARBITER -- requirements
Module: pipeline_mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, giving the maximum consecutive data grants while an instruction request waits.
REQ-002 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port inst_read  input  1  instruction fetch request from the pipeline.
REQ-005 The block SHALL have port inst_addr  input  32  instruction fetch address.
REQ-006 The block SHALL have port inst_resp  output  1  instruction fetch done, one-cycle pulse.
REQ-007 The block SHALL have port inst_rdata  output  32  fetched instruction, valid only while inst_resp is 1.
REQ-008 The block SHALL have ports data_read and data_write, each input 1, the data read and data write requests.
REQ-009 The block SHALL have ports data_addr (input 32), data_wdata (input 32) and data_mbe (input 4): data address, write data and byte enables.
REQ-010 The block SHALL have port data_resp  output  1  data access done, one-cycle pulse.
REQ-011 The block SHALL have port data_rdata  output  32  load data, valid only while data_resp is 1.
REQ-012 The block SHALL have ports mem_read and mem_write, each output 1, the downstream shared-port requests.
REQ-013 The block SHALL have ports mem_addr (output 32), mem_wdata (output 32) and mem_mbe (output 4): downstream address, write data and byte enables.
REQ-014 The block SHALL have ports mem_resp (input 1) and mem_rdata (input 32): downstream completion and read data.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, INST, DATA.
REQ-016 In IDLE, mem_read and mem_write SHALL be 0, and inst_resp and data_resp SHALL be 0.
REQ-017 In IDLE, a data request SHALL win when (data_read|data_write) is 1 and either inst_read is 0 or starve_cnt < STARVE_LIMIT; the next state is DATA.
REQ-018 Otherwise in IDLE, inst_read=1 SHALL cause the next state to be INST; with no request, the FSM stays in IDLE.
REQ-019 On the grant edge, the block SHALL capture the winner's address, wdata, mbe and operation into registers; mem_* SHALL be driven only from these registers.
REQ-020 A request sampled in IDLE at cycle N SHALL appear on mem_read or mem_write at cycle N+1.
REQ-021 In INST, mem_read SHALL be 1, mem_write 0, mem_mbe 4'b1111, and mem_wdata 0.
REQ-022 In DATA with a captured write, mem_write SHALL be 1 and mem_read 0; with a captured read, mem_read SHALL be 1 and mem_write 0.
REQ-023 If data_read and data_write are both 1 at grant, the block SHALL capture a write.
REQ-024 The block SHALL hold all mem_* outputs stable until mem_resp=1, regardless of upstream signal changes.
REQ-025 In cycle R with mem_resp=1, the block SHALL set inst_resp (INST) or data_resp (DATA) to 1 for exactly that cycle, pass mem_rdata combinationally to the matching *_rdata, and return to IDLE at R+1.
REQ-026 The minimum gap between consecutive grants SHALL be one IDLE cycle; the best-case request-to-resp latency is 1 + downstream latency.
REQ-027 The block SHALL never assert inst_resp and data_resp in the same cycle.
REQ-028 inst_rdata and data_rdata SHALL be 0 when their resp is 0.
REQ-029 starve_cnt SHALL be a counter of width clog2(STARVE_LIMIT+1) that increments on a DATA grant with inst_read=1, saturates at STARVE_LIMIT, and clears to 0 on every INST grant.
REQ-030 A DATA grant with inst_read=0 SHALL leave starve_cnt unchanged.
REQ-031 mem_resp received in IDLE SHALL be ignored, with no upstream resp and no state change.

Reset
REQ-032 While reset=0, the FSM SHALL be in IDLE and starve_cnt and all captured registers SHALL be 0, independent of clk.
REQ-033 While reset=0, all outputs SHALL be 0.
REQ-034 A reset asserted mid-transaction SHALL abandon the transaction: no resp is issued, and a later mem_resp is ignored per REQ-031.
REQ-035 After reset deasserts, the first grant SHALL be possible at the first rising edge.

Verification
REQ-036 Single fetch: inst_read=1, inst_addr=0x60 at cycle 0, mem_resp=1 with mem_rdata=0x00000013 at cycle 3 -> mem_read=1 and mem_addr=0x60 in cycles 1-3, inst_resp=1 and inst_rdata=0x13 in cycle 3, IDLE at cycle 4.
REQ-037 Simultaneous requests: inst_read=1 and data_write=1 with addr 0x100, wdata 0xDEADBEEF, mbe 4'b0011 -> DATA granted first with mem_write=1, mem_mbe=4'b0011, mem_wdata=0xDEADBEEF; INST follows only after data_resp, with one IDLE cycle between.
REQ-038 Starvation bound: with STARVE_LIMIT=4, data_read and inst_read held continuously and mem_resp arriving 1 cycle after every request -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-039 Upstream change during a transaction: data_addr changes from 0x200 to 0x300 while in DATA -> mem_addr stays 0x200 until mem_resp.
REQ-040 Reset mid-operation: reset=0 in the INST state before mem_resp -> all outputs are 0 immediately; a mem_resp pulse after reset release gives inst_resp=0.
REQ-041 Illegal combination: data_read=1 and data_write=1 at grant -> mem_write=1 and mem_read=0.
